// File: rtl/alu_pkg.sv
// Shared ALU types: op codes, FSM states, result flags.
// Helpers classify shift and branch ops.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_XOR = 4'b0001,
    ALU_SUB = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_ADD = 4'b0100,
    ALU_BGE = 4'b0101,
    ALU_BNE = 4'b0110,
    ALU_SRA = 4'b0111,
    ALU_BEQ = 4'b1000,
    ALU_SLL = 4'b1001,
    ALU_LUI = 4'b1010,
    ALU_SRL = 4'b1100,
    ALU_BLT = 4'b1101,
    ALU_SLT = 4'b1110
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic taken;
    logic illegal;
  } alu_flags_t;

  function automatic logic is_shift(alu_op_e op);
    return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction

  function automatic logic is_branch(alu_op_e op);
    return op inside {ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE};
  endfunction

endpackage

// File: rtl/alu_exec_unit_shifter.sv
// Serial shifter, 1 bit/cycle: load latches data/count/dir/arith.
// Ports: clear, load, dir(1=right), arith, data, count -> value, done.
module alu_serial_shifter #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             dir,
  input  logic             arith,
  input  logic [WIDTH-1:0] data,
  input  logic [SW-1:0]    count,
  output logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] val_q;
  logic [SW-1:0]    cnt_q;
  logic             dir_q;
  logic             ari_q;
  logic [WIDTH-1:0] val_nxt;

  always_comb begin
    val_nxt = val_q;
    if (dir_q)
      val_nxt = {ari_q & val_q[WIDTH-1],
                 val_q[WIDTH-1:1]};
    else
      val_nxt = {val_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
      ari_q <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      val_q <= data;
      cnt_q <= count;
      dir_q <= dir;
      ari_q <= arith;
    end else if (cnt_q != '0) begin
      val_q <= val_nxt;
      cnt_q <= cnt_q - SW'(1);
    end
  end

  // done marks the cycle whose edge performs the last shift
  assign done  = (cnt_q == SW'(1));
  assign value = val_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU, valid/ready on both sides; serial shifts stall.
// Macro ALU_BARREL_SHIFT_EN selects a single-cycle barrel shifter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch_taken,
  output logic             illegal_op
);

  localparam int SW = $clog2(WIDTH);

  alu_state_e       state_q;
  alu_state_e       state_d;
  alu_op_e          opc;
  logic [SW-1:0]    shamt;
  logic             lt;
  logic             eq;
  logic [WIDTH-1:0] res_c;
  alu_flags_t       flg_c;
  logic [WIDTH-1:0] res_q;
  alu_flags_t       flg_q;
  logic             use_sh_q;
  logic             accept;
  logic             go_shift;
  logic [WIDTH-1:0] sh_value;
  logic             sh_done;

  assign opc   = alu_op_e'(op);
  assign shamt = src_b[SW-1:0];
  assign lt    = $signed(src_a) < $signed(src_b);
  assign eq    = (src_a == src_b);

  always_comb begin
    res_c = '0;
    flg_c = '0;
    unique case (opc)
      ALU_AND: res_c = src_a & src_b;
      ALU_XOR: res_c = src_a ^ src_b;
      ALU_SUB: res_c = src_a - src_b;
      ALU_OR:  res_c = src_a | src_b;
      ALU_ADD: res_c = src_a + src_b;
      ALU_LUI: res_c = src_b;
      ALU_SLT: res_c = WIDTH'(lt);
      ALU_BGE: flg_c.taken = !lt;
      ALU_BLT: flg_c.taken = lt;
      ALU_BEQ: flg_c.taken = eq;
      ALU_BNE: flg_c.taken = !eq;
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL: res_c = src_a << shamt;
      ALU_SRL: res_c = src_a >> shamt;
      ALU_SRA: res_c = $signed(src_a) >>> shamt;
`else
      // only shamt==0 completes here; others go serial
      ALU_SLL: res_c = src_a;
      ALU_SRL: res_c = src_a;
      ALU_SRA: res_c = src_a;
`endif
      default: flg_c.illegal = 1'b1;
    endcase
    if (is_branch(opc))
      res_c = WIDTH'(flg_c.taken);
  end

  assign in_ready = (state_q == IDLE) ||
                    ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready && !flush;

`ifdef ALU_BARREL_SHIFT_EN
  assign go_shift = 1'b0;
  assign sh_value = '0;
  assign sh_done  = 1'b0;
`else
  assign go_shift = is_shift(opc) && (shamt != '0);

  alu_serial_shifter #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .load  (accept && go_shift),
    .dir   (opc != ALU_SLL),
    .arith (opc == ALU_SRA),
    .data  (src_a),
    .count (shamt),
    .value (sh_value),
    .done  (sh_done)
  );
`endif

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (1'b1)
        (state_q == IDLE): begin
          if (accept)
            state_d = go_shift ? SHIFT : DONE;
        end
        (state_q == SHIFT): begin
          if (sh_done)
            state_d = DONE;
        end
        (state_q == DONE): begin
          if (accept)
            state_d = go_shift ? SHIFT : DONE;
          else if (out_ready)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      res_q    <= '0;
      flg_q    <= '0;
      use_sh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        res_q    <= '0;
        flg_q    <= '0;
        use_sh_q <= 1'b0;
      end else if (accept) begin
        res_q    <= go_shift ? '0 : res_c;
        flg_q    <= go_shift ? '0 : flg_c;
        use_sh_q <= 1'b0;
      end else if ((state_q == SHIFT) && sh_done) begin
        use_sh_q <= 1'b1;
      end
    end
  end

  // a finished serial shift is read straight from the shifter register
  assign result       = use_sh_q ? sh_value : res_q;
  assign branch_taken = flg_q.taken;
  assign illegal_op   = flg_q.illegal;
  assign out_valid    = (state_q == DONE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32).
// Honours ALU_BARREL_SHIFT_EN for expected shift latency.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;
  logic        illegal_op;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .src_a        (src_a),
    .src_b        (src_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .illegal_op   (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] o,
                      input logic [31:0] a,
                      input logic [31:0] b);
    in_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 4'd0;
    src_a = '0;
    src_b = '0;
    step();
    step();
    total_cnt++;
    if ({out_valid, result, branch_taken, illegal_op} !== 35'd0)
      $display("FAIL reset_outs: got ov=%0b res=%h bt=%0b il=%0b want all 0",
               out_valid, result, branch_taken, illegal_op);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_idle: got ir=%0b ov=%0b want ir=1 ov=0",
               in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_add();
    send(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    total_cnt++;
    if (out_valid !== 1'b1)
      $display("FAIL add_latency: got ov=%0b want 1", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (result !== 32'h8000_0000 || branch_taken !== 1'b0)
      $display("FAIL add_result: got %h bt=%0b want 80000000 bt=0",
               result, branch_taken);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_logic();
    logic [3:0]  vo [9];
    logic [31:0] va [9];
    logic [31:0] vb [9];
    logic [31:0] vr [9];
    logic        vt [9];
    vo[0] = ALU_AND; va[0] = 32'hF0F0_00FF; vb[0] = 32'h0FF0_0F0F;
    vr[0] = 32'h00F0_000F; vt[0] = 1'b0;
    vo[1] = ALU_XOR; va[1] = 32'hFFFF_0000; vb[1] = 32'h0F0F_0F0F;
    vr[1] = 32'hF0F0_0F0F; vt[1] = 1'b0;
    vo[2] = ALU_OR;  va[2] = 32'h1234_0000; vb[2] = 32'h0000_5678;
    vr[2] = 32'h1234_5678; vt[2] = 1'b0;
    vo[3] = ALU_SLT; va[3] = 32'hFFFF_FFFE; vb[3] = 32'h1;
    vr[3] = 32'h1; vt[3] = 1'b0;
    vo[4] = ALU_SLT; va[4] = 32'h5; vb[4] = 32'h3;
    vr[4] = 32'h0; vt[4] = 1'b0;
    vo[5] = ALU_LUI; va[5] = 32'h1111_1111; vb[5] = 32'hABCD_E000;
    vr[5] = 32'hABCD_E000; vt[5] = 1'b0;
    vo[6] = ALU_BEQ; va[6] = 32'h7; vb[6] = 32'h7;
    vr[6] = 32'h1; vt[6] = 1'b1;
    vo[7] = ALU_BNE; va[7] = 32'h7; vb[7] = 32'h7;
    vr[7] = 32'h0; vt[7] = 1'b0;
    vo[8] = ALU_SUB; va[8] = 32'h0; vb[8] = 32'h1;
    vr[8] = 32'hFFFF_FFFF; vt[8] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send(vo[i], va[i], vb[i]);
      total_cnt++;
      if (out_valid !== 1'b1 || result !== vr[i] ||
          branch_taken !== vt[i] || illegal_op !== 1'b0)
        $display("FAIL logic_%0d: got ov=%0b res=%h bt=%0b il=%0b want ov=1 res=%h bt=%0b il=0",
                 i, out_valid, result, branch_taken, illegal_op,
                 vr[i], vt[i]);
      else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_branch();
    send(ALU_BLT, 32'hFFFF_FFFF, 32'h1);
    total_cnt++;
    if (branch_taken !== 1'b1 || result !== 32'h1)
      $display("FAIL blt: got bt=%0b res=%h want bt=1 res=1",
               branch_taken, result);
    else pass_cnt++;
    consume();
    send(ALU_BGE, 32'hFFFF_FFFF, 32'h1);
    total_cnt++;
    if (branch_taken !== 1'b0 || result !== 32'h0)
      $display("FAIL bge: got bt=%0b res=%h want bt=0 res=0",
               branch_taken, result);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_shift();
    logic [3:0]  so [5];
    logic [31:0] sa [5];
    logic [4:0]  ss [5];
    logic [31:0] sr [5];
    int lat;
    int exp_lat;
    int ir_bad;
    so[0] = ALU_SRA; sa[0] = 32'h8000_0000; ss[0] = 5'd4;
    sr[0] = 32'hF800_0000;
    so[1] = ALU_SRL; sa[1] = 32'h8000_0000; ss[1] = 5'd31;
    sr[1] = 32'h0000_0001;
    so[2] = ALU_SLL; sa[2] = 32'h4000_0001; ss[2] = 5'd1;
    sr[2] = 32'h8000_0002;
    so[3] = ALU_SRL; sa[3] = 32'h8000_0000; ss[3] = 5'd0;
    sr[3] = 32'h8000_0000;
    so[4] = ALU_SRA; sa[4] = 32'h7FFF_FFF0; ss[4] = 5'd4;
    sr[4] = 32'h07FF_FFFF;
    for (int i = 0; i < 5; i++) begin
`ifdef ALU_BARREL_SHIFT_EN
      exp_lat = 1;
`else
      exp_lat = (ss[i] == 5'd0) ? 1 : int'(ss[i]) + 1;
`endif
      send(so[i], sa[i], 32'hABCD_EF00 | {27'd0, ss[i]});
      lat = 1;
      ir_bad = 0;
      while (!out_valid && lat < 40) begin
        if (in_ready !== 1'b0) ir_bad++;
        step();
        lat++;
      end
      total_cnt++;
      if (lat !== exp_lat || ir_bad !== 0)
        $display("FAIL shift_lat_%0d: got lat=%0d ir_hi=%0d want lat=%0d ir_hi=0",
                 i, lat, ir_bad, exp_lat);
      else pass_cnt++;
      total_cnt++;
      if (result !== sr[i])
        $display("FAIL shift_res_%0d: got %h want %h", i, result, sr[i]);
      else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_back_to_back();
    send(ALU_ADD, 32'd2, 32'd3);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || result !== 32'd5 || in_ready !== 1'b0)
        $display("FAIL stall_%0d: got ov=%0b res=%h ir=%0b want ov=1 res=5 ir=0",
                 i, out_valid, result, in_ready);
      else pass_cnt++;
      step();
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = ALU_SUB;
    src_a = 32'd5;
    src_b = 32'd7;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL b2b_ready: got ir=%0b want 1", in_ready);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE)
      $display("FAIL b2b_result: got ov=%0b res=%h want ov=1 res=fffffffe",
               out_valid, result);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_flush();
    int ov_seen;
    send(ALU_SLL, 32'h1, 32'd20);
`ifndef ALU_BARREL_SHIFT_EN
    for (int i = 0; i < 4; i++) step();
`endif
    flush = 1'b1;
    step();
    flush = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_idle: got ov=%0b ir=%0b want ov=0 ir=1",
               out_valid, in_ready);
    else pass_cnt++;
    ov_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid !== 1'b0) ov_seen++;
      step();
    end
    total_cnt++;
    if (ov_seen !== 0)
      $display("FAIL flush_quiet: got %0d valid cycles want 0", ov_seen);
    else pass_cnt++;
    send(ALU_ADD, 32'd10, 32'd20);
    total_cnt++;
    if (out_valid !== 1'b1 || result !== 32'd30)
      $display("FAIL flush_next: got ov=%0b res=%h want ov=1 res=1e",
               out_valid, result);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_illegal();
    logic [3:0] ill [2];
    ill[0] = 4'b1111;
    ill[1] = 4'b1011;
    for (int i = 0; i < 2; i++) begin
      send(ill[i], 32'h1234_5678, 32'h9ABC_DEF0);
      total_cnt++;
      if (out_valid !== 1'b1 || illegal_op !== 1'b1 ||
          result !== 32'h0 || branch_taken !== 1'b0)
        $display("FAIL illegal_%0d: got ov=%0b il=%0b res=%h bt=%0b want ov=1 il=1 res=0 bt=0",
                 i, out_valid, illegal_op, result, branch_taken);
      else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_reset_mid_shift();
    int ov_seen;
    send(ALU_SRL, 32'hFFFF_FFFF, 32'd31);
    step();
    step();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, result, branch_taken, illegal_op} !== 35'd0)
      $display("FAIL rst_mid: got ov=%0b res=%h bt=%0b il=%0b want all 0",
               out_valid, result, branch_taken, illegal_op);
    else pass_cnt++;
    step();
    step();
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) ov_seen++;
      step();
    end
    total_cnt++;
    if (ov_seen !== 0 || in_ready !== 1'b1)
      $display("FAIL rst_mid_after: got valid=%0d ir=%0b want 0 and 1",
               ov_seen, in_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_logic();
    test_branch();
    test_shift();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
